ahb_lite_cmd_master: RTL

- Command-queue-driven AHB-Lite master; sits directly upstream of the decoder/mux/slave fabric and drives the shared address/control/write-data bus.
- Software or testbench logic pushes single-transfer commands (write, addr, data, size) into an internal FIFO.
- The block issues them as pipelined NONSEQ SINGLE transfers, honours HREADY wait states and the two-cycle HRESP error response, and returns one in-order response per command.

---
 rtl/ahb_lite_cmd_master.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_cmd_master.sv
// ahb_lite_cmd_master
// Command-queue-driven AHB-Lite master. Single-transfer commands are pushed
// into a DEPTH-entry FIFO and issued as pipelined NONSEQ SINGLE transfers.
// HREADY wait states and the two-cycle ERROR response are honoured, and one
// in-order response is returned per command.
//
// Optional feature macro: AHB_ALIGN_CHECK_EN
//   defined   : misaligned head commands (Halfword addr[0]=1, Word addr[1:0]!=0)
//               are not issued; they are popped and answered with rsp_error=1.
//   undefined : no alignment check, commands are issued verbatim.
//
// Ports
//   HCLK, HRESETn              clock, async active-low reset
//   cmd_valid/cmd_ready        command push handshake
//   cmd_write/addr/wdata/size  command payload
//   rsp_valid/write/rdata/error one-cycle response pulse per command
//   fifo_count                 queued command count
//   HADDR..HWDATA              AHB-Lite master address/control/write data
//   HREADY, HRESP, HRDATA      AHB-Lite slave-side return signals
module ahb_lite_cmd_master #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  input  logic [2:0]       cmd_size,
  output logic             rsp_valid,
  output logic             rsp_write,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_error,
  output logic [PTR_W:0]   fifo_count,
  output logic [31:0]      HADDR,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic [1:0]       HTRANS,
  output logic             HMASTLOCK,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic             HRESP,
  input  logic [31:0]      HRDATA
);

  localparam logic [1:0] DP_NONE     = 2'd0;
  localparam logic [1:0] DP_ACTIVE   = 2'd1;
  localparam logic [1:0] DP_ERR2     = 2'd2;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;

  // command storage
  logic [DEPTH-1:0]        mem_write_q, mem_write_d;
  logic [DEPTH-1:0][31:0]  mem_addr_q,  mem_addr_d;
  logic [DEPTH-1:0][31:0]  mem_wdata_q, mem_wdata_d;
  logic [DEPTH-1:0][2:0]   mem_size_q,  mem_size_d;
  logic [PTR_W:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  // bus / tracker state
  logic [1:0]  dp_q, dp_d;
  logic        dp_write_q, dp_write_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d, rsp_error_q, rsp_error_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        empty, full, push, pop, issue, accept, reject, head_misal;
  logic        head_write;
  logic [31:0] head_addr, head_wdata;
  logic [2:0]  head_size;

  // Head is read from registered storage only, so a command pushed at edge N
  // cannot reach the bus before the cycle after edge N.
  assign head_write = mem_write_q[rd_ptr_q[PTR_W-1:0]];
  assign head_addr  = mem_addr_q [rd_ptr_q[PTR_W-1:0]];
  assign head_wdata = mem_wdata_q[rd_ptr_q[PTR_W-1:0]];
  assign head_size  = mem_size_q [rd_ptr_q[PTR_W-1:0]];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

`ifdef AHB_ALIGN_CHECK_EN
  assign head_misal = !empty && (((head_size == 3'd1) && head_addr[0]) ||
                                 ((head_size == 3'd2) && (head_addr[1:0] != 2'b00)));
`else
  assign head_misal = 1'b0;
`endif

  // ERR2 cancels the pending address phase; the head stays queued for re-issue.
  assign issue  = !empty && (dp_q != DP_ERR2) && !head_misal;
  assign accept = issue && HREADY;
  // A reject takes a data-phase slot, so it waits until nothing is in flight.
  assign reject = head_misal && (dp_q == DP_NONE);
  assign push   = cmd_valid && !full;
  assign pop    = accept || reject;

  always_comb begin
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    if (push) begin
      mem_write_d[wr_ptr_q[PTR_W-1:0]] = cmd_write;
      mem_addr_d [wr_ptr_q[PTR_W-1:0]] = cmd_addr;
      mem_wdata_d[wr_ptr_q[PTR_W-1:0]] = cmd_wdata;
      mem_size_d [wr_ptr_q[PTR_W-1:0]] = cmd_size;
    end
    wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
  end

  // data phase tracker and response generation
  always_comb begin
    dp_d        = dp_q;
    dp_write_d  = dp_write_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = 32'h0;
    case (dp_q)
      DP_ACTIVE: begin
        if (HREADY) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = dp_write_q;
          rsp_error_d = HRESP;
          rsp_rdata_d = dp_write_q ? 32'h0 : HRDATA;
          dp_d        = DP_NONE;
        end else if (HRESP) begin
          dp_d = DP_ERR2;
        end
      end
      DP_ERR2: begin
        if (HREADY) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = dp_write_q;
          rsp_error_d = HRESP;
          rsp_rdata_d = dp_write_q ? 32'h0 : HRDATA;
          dp_d        = DP_NONE;
        end
      end
      default: ;
    endcase
    if (accept) begin
      dp_d       = DP_ACTIVE;
      dp_write_d = head_write;
      if (head_write) hwdata_d = head_wdata;
    end
    if (reject) begin
      rsp_valid_d = 1'b1;
      rsp_write_d = head_write;
      rsp_error_d = 1'b1;
      rsp_rdata_d = 32'h0;
    end
  end

  // Address/control follow the head while issuing, otherwise hold last value.
  always_comb begin
    haddr_d  = issue ? head_addr  : haddr_q;
    hwrite_d = issue ? head_write : hwrite_q;
    hsize_d  = issue ? head_size  : hsize_q;
  end

  always_ff @(posedge HCLK) begin
    mem_write_q <= mem_write_d;
    mem_addr_q  <= mem_addr_d;
    mem_wdata_q <= mem_wdata_d;
    mem_size_q  <= mem_size_d;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      dp_q        <= DP_NONE;
      dp_write_q  <= 1'b0;
      hwdata_q    <= 32'h0;
      haddr_q     <= 32'h0;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      dp_q        <= dp_d;
      dp_write_q  <= dp_write_d;
      hwdata_q    <= hwdata_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready  = !full;
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign HTRANS     = issue ? HTRANS_NSEQ : HTRANS_IDLE;
  assign HADDR      = haddr_d;
  assign HWRITE     = hwrite_d;
  assign HSIZE      = hsize_d;
  assign HWDATA     = hwdata_q;
  assign HBURST     = 3'b000;
  assign HPROT      = 4'b0011;
  assign HMASTLOCK  = 1'b0;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_error  = rsp_error_q;

endmodule
